fdiv_seq: RTL and testbench

Parametrised sequential IEEE-754-style floating-point divider, successor to the single-cycle combinational divider.
- Operands are packed {sign, exp, frac}.
- Quotient is computed one bit per cycle by a radix-2 restoring iteration.
- Round-to-nearest-even, full special-case handling and IEEE exception flags.
- Sits in the FPU execute stage behind valid/ready handshakes, so one shared divider serves the whole datapath.

---
 rtl/fdiv_pkg.sv | 41 ++++
 rtl/fdiv_if.sv | 30 +++
 rtl/fdiv_round.sv | 74 +++++++
 rtl/fdiv_seq.sv | 167 ++++++++++++++++
 tb/tb_fdiv_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fdiv_pkg.sv
// Shared definitions for the sequential FP divider: FSM encoding, flag bit
// positions, rounding-mode codes and special-value pattern helpers.
package fdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RND  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // flags = {invalid, div_by_zero, overflow, underflow, inexact}
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Patterns are built 64 bits wide; callers cast down to their word width.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int frac_w);
        return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
    endfunction

    function automatic logic [63:0] inf_bits(input logic sign, input int exp_w, input int frac_w);
        return ({63'd0, sign} << (exp_w + frac_w)) | (((64'd1 << exp_w) - 64'd1) << frac_w);
    endfunction

    function automatic logic [63:0] zero_bits(input logic sign, input int exp_w, input int frac_w);
        return {63'd0, sign} << (exp_w + frac_w);
    endfunction

endpackage

// File: rtl/fdiv_if.sv
// Valid/ready operand and result bundle for fdiv_seq.
// FDIV_ROUND_MODE_EN adds the rounding-mode field rm.
interface fdiv_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;
`ifdef FDIV_ROUND_MODE_EN
    logic [2:0]   rm;

    modport master (output in_valid, a, b, rm, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, a, b, rm, out_ready,
                    output in_ready, out_valid, result, flags);
`else
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, flags);
`endif
endinterface

// File: rtl/fdiv_round.sv
// Combinational normalise/round/pack of a raw quotient; shared with the
// multiplier, so it takes the rounding mode as a plain input.
module fdiv_round
    import fdiv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [FRAC_W+2:0]       q,
    input  logic                    rem_nz,
    input  logic [2:0]              rm,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [4:0]              flags
);
    localparam int Q_W     = FRAC_W + 3;
    localparam int EXP_TOP = (1 << EXP_W) - 1;

    logic [FRAC_W:0]         mant;
    logic [FRAC_W+1:0]       mant_sum;
    logic [FRAC_W-1:0]       frac;
    logic signed [EXP_W+1:0] exp_n;
    logic                    guard, sticky, rnd_up, to_zero;

    always_comb begin
        // q in (0.5, 2): a clear MSB means one extra normalising shift
        if (q[Q_W-1]) begin
            mant   = q[Q_W-1:2];
            guard  = q[1];
            sticky = q[0] | rem_nz;
            exp_n  = exp_in;
        end else begin
            mant   = q[Q_W-2:1];
            guard  = q[0];
            sticky = rem_nz;
            exp_n  = exp_in - (EXP_W+2)'(1);
        end

        case (rm)
            RM_RTZ:  rnd_up = 1'b0;
            RM_RDN:  rnd_up = sign & (guard | sticky);
            RM_RUP:  rnd_up = ~sign & (guard | sticky);
            default: rnd_up = guard & (sticky | mant[0]);
        endcase
        to_zero = (rm == RM_RTZ) || (rm == RM_RDN && !sign) || (rm == RM_RUP && sign);

        mant_sum = {1'b0, mant} + (FRAC_W+2)'(rnd_up);
        if (mant_sum[FRAC_W+1]) begin
            frac  = mant_sum[FRAC_W:1];
            exp_n = exp_n + (EXP_W+2)'(1);
        end else begin
            frac  = mant_sum[FRAC_W-1:0];
        end

        flags = '0;
        if (int'(exp_n) >= EXP_TOP) begin
            flags[FLAG_OF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
            if (to_zero)
                result = {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
            else
                result = (EXP_W+FRAC_W+1)'(inf_bits(sign, EXP_W, FRAC_W));
        end else if (int'(exp_n) <= 0) begin
            flags[FLAG_UF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
            result = (EXP_W+FRAC_W+1)'(zero_bits(sign, EXP_W, FRAC_W));
        end else begin
            flags[FLAG_NX] = guard | sticky;
            result = {sign, exp_n[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential radix-2 restoring FP divider behind valid/ready handshakes.
// Build option FDIV_ROUND_MODE_EN: per-operation rounding mode (default RNE only).
module fdiv_seq
    import fdiv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic  clk,
    input  logic  rst,
    fdiv_if.slave bus
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int Q_W   = FRAC_W + 3;
    localparam int BIAS  = bias_of(EXP_W);
    localparam int CNT_W = $clog2(Q_W);

    state_t                  state_reg, state_next;
    logic                    in_ready;
    logic [CNT_W-1:0]        cnt_reg;
    logic [Q_W-1:0]          q_reg;
    logic [FRAC_W+1:0]       rem_reg;
    logic [FRAC_W:0]         mb_reg;
    logic signed [EXP_W+1:0] exp_reg;
    logic                    sign_reg;
    logic [W-1:0]            result_reg;
    logic [4:0]              flags_reg;
    logic                    out_valid_reg;
    logic [2:0]              rm_w;

    logic                    sa, sb;
    logic [EXP_W-1:0]        ea, eb;
    logic [FRAC_W-1:0]       fa, fb;
    logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic                    special, accept;
    logic [W-1:0]            sp_result;
    logic [4:0]              sp_flags;
    logic [EXP_W+1:0]        exp_init;
    logic                    rem_ge;
    logic [FRAC_W+1:0]       rem_diff, rem_sel;
    logic [W-1:0]            rnd_result;
    logic [4:0]              rnd_flags;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    // exp==0 covers zero and flushed subnormals alike
    assign a_zero  = (ea == '0);
    assign a_inf   = (&ea) && (fa == '0);
    assign a_nan   = (&ea) && (fa != '0);
    assign b_zero  = (eb == '0);
    assign b_inf   = (&eb) && (fb == '0);
    assign b_nan   = (&eb) && (fb != '0);
    assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign accept  = bus.in_valid && in_ready;

    always_comb begin
        sp_result = W'(zero_bits(sa ^ sb, EXP_W, FRAC_W));
        sp_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_result        = W'(qnan_bits(EXP_W, FRAC_W));
            sp_flags[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            sp_result = W'(inf_bits(sa ^ sb, EXP_W, FRAC_W));
        end else if (b_zero) begin
            sp_result        = W'(inf_bits(sa ^ sb, EXP_W, FRAC_W));
            sp_flags[FLAG_DZ] = 1'b1;
        end
    end

    assign exp_init = {2'b00, ea} - {2'b00, eb} + (EXP_W+2)'(BIAS);

    assign rem_ge   = (rem_reg >= {1'b0, mb_reg});
    assign rem_diff = rem_reg - {1'b0, mb_reg};
    assign rem_sel  = rem_ge ? rem_diff : rem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.in_valid) state_next = special ? ST_OUT : ST_DIV;
            ST_DIV:  if (cnt_reg == CNT_W'(Q_W - 1)) state_next = ST_RND;
            ST_RND:  state_next = ST_OUT;
            ST_OUT:  if (out_valid_reg && bus.out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            q_reg         <= '0;
            rem_reg       <= '0;
            mb_reg        <= '0;
            exp_reg       <= '0;
            sign_reg      <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) begin
                    sign_reg <= sa ^ sb;
                    cnt_reg  <= '0;
                    q_reg    <= '0;
                    rem_reg  <= {2'b01, fa};
                    mb_reg   <= {1'b1, fb};
                    exp_reg  <= exp_init;
                    if (special) begin
                        result_reg <= sp_result;
                        flags_reg  <= sp_flags;
                    end
                end
                ST_DIV: begin
                    q_reg   <= {q_reg[Q_W-2:0], rem_ge};
                    rem_reg <= rem_sel << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_RND: begin
                    result_reg <= rnd_result;
                    flags_reg  <= rnd_flags;
                end
                ST_OUT: begin
                    // valid rises one cycle after entering OUT, drops on the handshake
                    if (!out_valid_reg)      out_valid_reg <= 1'b1;
                    else if (bus.out_ready)  out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FDIV_ROUND_MODE_EN
    logic [2:0] rm_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rm_reg <= RM_RNE;
        else if (accept) rm_reg <= bus.rm;
    end
    assign rm_w = rm_reg;
`else
    assign rm_w = RM_RNE;
`endif

    fdiv_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
        .sign   (sign_reg),
        .exp_in (exp_reg),
        .q      (q_reg),
        .rem_nz (|rem_reg),
        .rm     (rm_w),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.flags     = flags_reg;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed self-checking bench for fdiv_seq (FP32): vector table plus
// backpressure and mid-operation reset sequences.
module tb_fdiv_seq;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fdiv_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();

    fdiv_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [31:0] res, input logic [4:0] flg, input int lat,
                       input string name);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.res = res; v.flg = flg; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called #1 after a clock edge; returns result, flags and accept-to-valid latency.
    task automatic run_op(input vec_t v, output logic [31:0] res, output logic [4:0] flg,
                          output int lat);
        bus.a = v.a;
        bus.b = v.b;
`ifdef FDIV_ROUND_MODE_EN
        bus.rm = v.rm;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        res = bus.result;
        flg = bus.flags;
        if (lat != 0) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, r0;
        logic [4:0]  f, f0;
        int          lat;
        vec_t        v;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef FDIV_ROUND_MODE_EN
        bus.rm        = 3'b000;
`endif

        //  a             b             rm      result        flags     lat
        add(32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 5'b00000, 28, "6/2");
        add(32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 5'b00001, 28, "1/3");
        add(32'h3F800000, 32'h3FC00000, 3'b000, 32'h3F2AAAAB, 5'b00001, 28, "1/1.5");
        add(32'hC0C00000, 32'h40000000, 3'b000, 32'hC0400000, 5'b00000, 28, "-6/2");
        add(32'h40000000, 32'h40000000, 3'b000, 32'h3F800000, 5'b00000, 28, "2/2");
        add(32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 5'b00101, 28, "ovf");
        add(32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 5'b00011, 28, "unf");
        add(32'hBF800000, 32'h00000000, 3'b000, 32'hFF800000, 5'b01000,  1, "-1/0");
        add(32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b10000,  1, "0/0");
        add(32'h7F800000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'b10000,  1, "inf/inf");
        add(32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b10000,  1, "nan/1");
        add(32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 5'b00000,  1, "inf/2");
        add(32'h3F800000, 32'hFF800000, 3'b000, 32'h80000000, 5'b00000,  1, "1/-inf");
        add(32'h00000001, 32'h3F800000, 3'b000, 32'h00000000, 5'b00000,  1, "sub/1");
        add(32'h3F800000, 32'h00000001, 3'b000, 32'h7F800000, 5'b01000,  1, "1/sub");
`ifdef FDIV_ROUND_MODE_EN
        add(32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 5'b00001, 28, "1/3 rtz");
        add(32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 5'b00101, 28, "ovf rtz");
        add(32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 5'b00001, 28, "-1/3 rdn");
        add(32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 5'b00001, 28, "1/3 rup");
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset result",    bus.result,         32'd0);
        chk("reset flags",     32'(bus.flags),     32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], r, f, lat);
            $display("op %-8s a=%h b=%h -> result=%h flags=%b lat=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].b, r, f, lat);
            chk({vecs[i].name, " result"},  r,        vecs[i].res);
            chk({vecs[i].name, " flags"},   32'(f),   32'(vecs[i].flg));
            chk({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held while stalled, new in_valid ignored until after handshake
        bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'h00000000; bus.b = 32'h00000000;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        chk("stall latency", 32'(lat), 32'd28);
        r0 = bus.result;
        f0 = bus.flags;
        chk("stall first result", r0, 32'h40400000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall result held", bus.result,          r0);
            chk("stall flags held",  32'(bus.flags),      32'(f0));
            chk("stall out_valid",   32'(bus.out_valid),  32'd1);
            chk("stall in_ready",    32'(bus.in_ready),   32'd0);
        end
        $display("op stall   result=%h flags=%b held for 5 cycles", r0, f0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post handshake out_valid", 32'(bus.out_valid), 32'd0);
        chk("post handshake in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("late accept in_ready",  32'(bus.in_ready),  32'd0);
        chk("late accept out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("late accept valid",  32'(bus.out_valid), 32'd1);
        chk("late accept result", bus.result,         32'h7FC00000);
        $display("op late    a=00000000 b=00000000 -> result=%h flags=%b", bus.result, bus.flags);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset pulsed ten cycles into DIV, then a clean operation
        bus.a = 32'h3F800000; bus.b = 32'h40400000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort result",    bus.result,         32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("op abort   reset during DIV, out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);
        v.a = 32'h40000000; v.b = 32'h40000000; v.rm = 3'b000;
        v.res = 32'h3F800000; v.flg = 5'b00000; v.lat = 28; v.name = "2/2 after abort";
        run_op(v, r, f, lat);
        $display("op %s a=%h b=%h -> result=%h flags=%b lat=%0d", v.name, v.a, v.b, r, f, lat);
        chk("after abort result",  r,        v.res);
        chk("after abort flags",   32'(f),   32'(v.flg));
        chk("after abort latency", 32'(lat), 32'(v.lat));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
